result_reader: RTL and testbench

- Receiving end of the engine wrapper's result write port: accepts words on the `wr_req` / `wr_data` strobe and buffers them in a DEPTH-entry ring FIFO.
- Hands the words to a downstream consumer over a valid/ready handshake.
- Groups popped words into frames of FRAME_LEN, flagging the last word of each frame and pulsing `frame_done` when a frame has been fully drained.
- Sits between the wrapper controller/shift register and the output/bus side of the SOC.

---
 rtl/result_reader_pkg.sv | 23 ++
 rtl/result_reader_if.sv | 30 +++
 rtl/result_reader_fifo.sv | 72 +++++++
 rtl/result_reader.sv | 100 ++++++++++
 tb/tb_result_reader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/result_reader_pkg.sv
// Shared types for the engine wrapper result path: reader and controller state encodings.
// Also carries a width helper so counters stay legal for degenerate parameter values.
package result_reader_pkg;

  typedef enum logic [1:0] {
    RR_IDLE   = 2'd0,
    RR_ACTIVE = 2'd1,
    RR_DONE   = 2'd2
  } rr_state_t;

  typedef enum logic [1:0] {
    WC_IDLE  = 2'd0,
    WC_LOAD  = 2'd1,
    WC_RUN   = 2'd2,
    WC_WRITE = 2'd3
  } wc_state_t;

  // A counter over n values needs at least one bit, even when n is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_reader_if.sv
// Write-strobe and valid/ready read bus of the result reader.
// master = writer/consumer side, slave = the reader itself.
interface result_reader_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH + 1);

  logic             wr_req;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             overflow;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ready;
  logic             rd_last;
  logic             frame_done;
  logic [LW-1:0]    level;

  modport master (
    output wr_req, wr_data, rd_ready,
    input  full, overflow, rd_valid, rd_data, rd_last, frame_done, level
  );

  modport slave (
    input  wr_req, wr_data, rd_ready,
    output full, overflow, rd_valid, rd_data, rd_last, frame_done, level
  );

endinterface

// File: rtl/result_reader_fifo.sv
// Ring-buffer FIFO with first-word fall-through read; push ignored when full, pop ignored when empty.
// Zero-cycle read latency; clear has priority over push and pop.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_dat,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !w_empty;

  // Storage is deliberately left out of reset; stale words are masked by the level.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_clr) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_pop_dat = r_mem[r_rd_ptr];
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_level   = r_level;

endmodule

// File: rtl/result_reader.sv
// Buffers result words, hands them out over valid/ready, and frames them in groups of FRAME_LEN.
// Writes while full are dropped and flagged sticky; frame_done pulses the cycle after a frame's last pop.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_clr,
  result_reader_if.slave rr_bus
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int FW = cnt_w(FRAME_LEN);

  logic [WIDTH-1:0] w_rd_dat;
  logic             w_full;
  logic             w_empty;
  logic [LW-1:0]    w_level;
  logic             w_pop;
  logic             w_last;

  rr_state_t        r_state;
  logic [FW-1:0]    r_fcnt;
  logic             r_frame_done;
  logic             r_overflow;

  sync_fifo_fwft #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst),
    .i_clr      (i_clr),
    .i_push     (rr_bus.wr_req),
    .i_push_dat (rr_bus.wr_data),
    .i_pop      (rr_bus.rd_ready),
    .o_pop_dat  (w_rd_dat),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (w_level)
  );

  assign w_pop  = !w_empty && rr_bus.rd_ready;
  assign w_last = !w_empty && (r_fcnt == FW'(FRAME_LEN - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= RR_IDLE;
      r_fcnt       <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (i_clr) begin
      r_state      <= RR_IDLE;
      r_fcnt       <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      // Full comes from the registered level, so a same-cycle pop does not save the write.
      if (rr_bus.wr_req && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_pop) begin
        r_fcnt <= w_last ? '0 : r_fcnt + 1'b1;
      end
      r_frame_done <= 1'b0;
      case (r_state)
        RR_IDLE, RR_DONE: begin
          if (w_pop && w_last) begin
            r_state      <= RR_DONE;
            r_frame_done <= 1'b1;
          end else if (w_pop) begin
            r_state <= RR_ACTIVE;
          end else begin
            r_state <= RR_IDLE;
          end
        end
        RR_ACTIVE: begin
          if (w_pop && w_last) begin
            r_state      <= RR_DONE;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= RR_IDLE;
      endcase
    end
  end

  assign rr_bus.full       = w_full;
  assign rr_bus.overflow   = r_overflow;
  assign rr_bus.rd_valid   = !w_empty;
  assign rr_bus.rd_data    = w_rd_dat;
  assign rr_bus.rd_last    = w_last;
  assign rr_bus.frame_done = r_frame_done;
  assign rr_bus.level      = w_level;

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader with an expected-word queue drained by a negedge monitor.
module tb_result_reader;

  typedef struct {
    logic [7:0] dat;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;

  int checks   = 0;
  int failures = 0;
  int fd_count = 0;
  logic exp_fd = 1'b0;
  exp_t exp_q[$];

  result_reader_if #(.WIDTH(8), .DEPTH(8)) bus ();

  result_reader #(
    .WIDTH     (8),
    .DEPTH     (8),
    .FRAME_LEN (8)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (clr),
    .rr_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one write cycle; queue the word only when it should be accepted.
  task automatic push_w(input logic [7:0] d, input bit acc, input bit last);
    exp_t e;
    bus.wr_req  = 1'b1;
    bus.wr_data = d;
    if (acc) begin
      e.dat  = d;
      e.last = last;
      exp_q.push_back(e);
    end
    tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic nxt_fd;
    if (!rst) begin
      exp_fd = 1'b0;
    end else begin
      chk("frame_done", {31'd0, bus.frame_done}, {31'd0, exp_fd});
      if (bus.frame_done === 1'b1) fd_count++;
      nxt_fd = 1'b0;
      if (bus.rd_valid && bus.rd_ready && !clr) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", {24'd0, bus.rd_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", {24'd0, bus.rd_data}, {24'd0, e.dat});
          chk("rd_last", {31'd0, bus.rd_last}, {31'd0, e.last});
          nxt_fd = e.last;
        end
      end
      exp_fd = nxt_fd;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_req   = 1'b0;
    bus.wr_data  = 8'h00;
    bus.rd_ready = 1'b0;
    repeat (3) tick();
    chk("rst_level", {28'd0, bus.level}, 32'd0);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_rd_last", {31'd0, bus.rd_last}, 32'd0);
    chk("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    rst = 1'b1;
    tick();

    // Basic FWFT ordering
    push_w(8'h11, 1, 0);
    push_w(8'h22, 1, 0);
    push_w(8'h33, 1, 0);
    bus.wr_req = 1'b0;
    chk("t1_level", {28'd0, bus.level}, 32'd3);
    chk("t1_rd_valid", {31'd0, bus.rd_valid}, 32'd1);
    chk("t1_rd_data", {24'd0, bus.rd_data}, 32'h11);
    bus.rd_ready = 1'b1;
    repeat (3) tick();
    bus.rd_ready = 1'b0;
    chk("t1_empty", {31'd0, bus.rd_valid}, 32'd0);
    chk("t1_q", exp_q.size(), 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // Overflow: ninth word dropped
    for (int i = 0; i < 9; i++) begin
      push_w(8'h40 + 8'(i), i < 8, i == 7);
      if (i == 7) begin
        chk("t2_full", {31'd0, bus.full}, 32'd1);
        chk("t2_ovf_before", {31'd0, bus.overflow}, 32'd0);
      end
    end
    bus.wr_req = 1'b0;
    chk("t2_overflow", {31'd0, bus.overflow}, 32'd1);
    chk("t2_level", {28'd0, bus.level}, 32'd8);
    bus.rd_ready = 1'b1;
    repeat (9) tick();
    bus.rd_ready = 1'b0;
    chk("t2_drained", {28'd0, bus.level}, 32'd0);
    chk("t2_q", exp_q.size(), 32'd0);
    chk("t2_ovf_sticky", {31'd0, bus.overflow}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t2_clr_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("t2_clr_level", {28'd0, bus.level}, 32'd0);

    // Two back-to-back frames streamed through
    fd_count = 0;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_w(8'h80 + 8'(i), 1, (i == 7) || (i == 15));
    bus.wr_req = 1'b0;
    repeat (3) tick();
    chk("t3_fd_count", fd_count, 32'd2);
    chk("t3_q", exp_q.size(), 32'd0);
    bus.rd_ready = 1'b0;

    // Steady level 4 with simultaneous push/pop across pointer wrap
    for (int i = 0; i < 4; i++) push_w(8'hC0 + 8'(i), 1, 0);
    chk("t4_level_pre", {28'd0, bus.level}, 32'd4);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_w(8'hD0 + 8'(i), 1, (i == 3) || (i == 11));
      chk("t4_level_hold", {28'd0, bus.level}, 32'd4);
    end
    bus.wr_req = 1'b0;
    repeat (4) tick();
    chk("t4_drained", {28'd0, bus.level}, 32'd0);
    chk("t4_q", exp_q.size(), 32'd0);
    bus.rd_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // Asynchronous reset mid-frame
    for (int i = 0; i < 8; i++) push_w(8'hE0 + 8'(i), 1, i == 7);
    bus.wr_req = 1'b0;
    bus.rd_ready = 1'b1;
    repeat (3) tick();
    bus.rd_ready = 1'b0;
    chk("t5_level5", {28'd0, bus.level}, 32'd5);
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    chk("t5_level", {28'd0, bus.level}, 32'd0);
    chk("t5_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("t5_full", {31'd0, bus.full}, 32'd0);
    chk("t5_rd_last", {31'd0, bus.rd_last}, 32'd0);
    chk("t5_frame_done", {31'd0, bus.frame_done}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    push_w(8'hAA, 1, 0);
    bus.wr_req = 1'b0;
    chk("t5_aa_data", {24'd0, bus.rd_data}, 32'hAA);
    chk("t5_aa_last", {31'd0, bus.rd_last}, 32'd0);
    chk("t5_aa_level", {28'd0, bus.level}, 32'd1);
    fd_count = 0;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 7; i++) push_w(8'hB0 + 8'(i), 1, i == 6);
    bus.wr_req = 1'b0;
    repeat (3) tick();
    chk("t5_fd_count", fd_count, 32'd1);
    chk("t5_q", exp_q.size(), 32'd0);
    bus.rd_ready = 1'b0;

    // Clear colliding with a push and a pop
    for (int i = 0; i < 3; i++) push_w(8'h60 + 8'(i), 1, 0);
    bus.wr_req = 1'b0;
    bus.rd_ready = 1'b1;
    tick();
    clr = 1'b1;
    bus.wr_req = 1'b1;
    bus.wr_data = 8'h77;
    tick();
    clr = 1'b0;
    bus.wr_req = 1'b0;
    bus.rd_ready = 1'b0;
    exp_q.delete();
    chk("t6_level", {28'd0, bus.level}, 32'd0);
    chk("t6_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("t6_overflow", {31'd0, bus.overflow}, 32'd0);
    repeat (2) tick();
    fd_count = 0;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_w(8'hF0 + 8'(i), 1, i == 7);
    bus.wr_req = 1'b0;
    repeat (3) tick();
    chk("t6_fd_count", fd_count, 32'd1);
    chk("t6_q", exp_q.size(), 32'd0);
    bus.rd_ready = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
